// File: rtl/temporizador_regressivo_pkg.sv
// Shared state encoding, BCD limits and preset clamp helper for the count-down timer.
package temporizador_regressivo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] clamp_bcd(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/temporizador_regressivo_bcd_digit_down.sv
// One BCD down-counting digit: clear/load/decrement with borrow chain, wraps to WRAP on borrow.
// Latency: one clock per update; borrow_out is combinational so a whole chain steps in one cycle.
module bcd_digit_down
    import temporizador_regressivo_pkg::*;
#(
    parameter logic [3:0] WRAP = BCD_MAX
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_ld,
    input  logic [3:0] i_ld_val,
    input  logic       i_en,
    input  logic       i_borrow_in,
    output logic [3:0] o_digit,
    output logic       o_borrow_out
);

    logic [3:0] r_digit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_digit <= 4'd0;
        end else if (i_clr) begin
            r_digit <= 4'd0;
        end else if (i_ld) begin
            r_digit <= i_ld_val;
        end else if (i_en && i_borrow_in) begin
            r_digit <= (r_digit == 4'd0) ? WRAP : r_digit - 4'd1;
        end
    end

    assign o_digit      = r_digit;
    assign o_borrow_out = i_borrow_in & (r_digit == 4'd0);

endmodule

// File: rtl/temporizador_regressivo.sv
// BCD SS.cc count-down timer with pause, preset load, and a timed alarm on expiry.
// Latency: start edge registers RUN, first decrement one tick later; no backpressure, runs every tick.
module temporizador_regressivo
    import temporizador_regressivo_pkg::*;
#(
    parameter int         ALARM_CYCLES = 200,
    parameter logic [3:0] SEG_DEZ_MAX  = 4'd5
) (
    input  logic       i_clk_100hz,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [3:0] i_preset_s_dez,
    input  logic [3:0] i_preset_s_uni,
    input  logic       i_start_stop,
    output logic [3:0] o_cs_unidade,
    output logic [3:0] o_cs_dezena,
    output logic [3:0] o_s_unidade,
    output logic [3:0] o_s_dezena,
    output logic       o_running,
    output logic       o_done
);

    localparam int             ALW        = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
    localparam logic [ALW-1:0] ALARM_LAST = ALW'(ALARM_CYCLES - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [ALW-1:0] r_alarm_cnt;
    logic [ALW-1:0] w_alarm_nxt;
    logic           r_start_prev;
    logic           r_running;
    logic           r_done;

    logic       w_edge, w_zero, w_one;
    logic       w_clr, w_ld, w_dec, w_dec_en;
    logic [3:0] w_cs_uni, w_cs_dez, w_s_uni, w_s_dez;
    logic       w_b_cs_uni, w_b_cs_dez, w_b_s_uni, w_b_s_dez;

    assign w_edge   = i_start_stop & ~r_start_prev;
    assign w_zero   = (w_s_dez == 4'd0) && (w_s_uni == 4'd0) && (w_cs_dez == 4'd0) && (w_cs_uni == 4'd0);
    assign w_one    = (w_s_dez == 4'd0) && (w_s_uni == 4'd0) && (w_cs_dez == 4'd0) && (w_cs_uni == 4'd1);
    // A borrow out of the top digit would mean counting below 00.00; never let it step.
    assign w_dec_en = w_dec & ~w_b_s_dez;

    always_comb begin
        w_state_nxt = r_state;
        w_alarm_nxt = r_alarm_cnt;
        w_clr       = 1'b0;
        w_ld        = 1'b0;
        w_dec       = 1'b0;
        if (i_clear) begin
            w_clr       = 1'b1;
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = '0;
        end else if (i_load && (r_state != ST_RUN)) begin
            w_ld        = 1'b1;
            w_state_nxt = ST_IDLE;
            w_alarm_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge && !w_zero) w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (w_edge) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_dec = 1'b1;
                        if (w_one) begin
                            w_state_nxt = ST_DONE;
                            w_alarm_nxt = '0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_edge) w_state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (w_edge || (r_alarm_cnt == ALARM_LAST)) begin
                        w_state_nxt = ST_IDLE;
                        w_alarm_nxt = '0;
                    end else begin
                        w_alarm_nxt = r_alarm_cnt + ALW'(1);
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk_100hz) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_alarm_cnt  <= '0;
            r_start_prev <= 1'b0;
            r_running    <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_alarm_cnt  <= w_alarm_nxt;
            r_start_prev <= i_start_stop;
            r_running    <= (w_state_nxt == ST_RUN);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    bcd_digit_down #(.WRAP(BCD_MAX)) u_cs_uni (
        .i_clk(i_clk_100hz), .i_rst_n(i_reset), .i_clr(w_clr), .i_ld(w_ld), .i_ld_val(4'd0),
        .i_en(w_dec_en), .i_borrow_in(1'b1), .o_digit(w_cs_uni), .o_borrow_out(w_b_cs_uni)
    );

    bcd_digit_down #(.WRAP(BCD_MAX)) u_cs_dez (
        .i_clk(i_clk_100hz), .i_rst_n(i_reset), .i_clr(w_clr), .i_ld(w_ld), .i_ld_val(4'd0),
        .i_en(w_dec_en), .i_borrow_in(w_b_cs_uni), .o_digit(w_cs_dez), .o_borrow_out(w_b_cs_dez)
    );

    bcd_digit_down #(.WRAP(BCD_MAX)) u_s_uni (
        .i_clk(i_clk_100hz), .i_rst_n(i_reset), .i_clr(w_clr), .i_ld(w_ld),
        .i_ld_val(clamp_bcd(i_preset_s_uni, BCD_MAX)),
        .i_en(w_dec_en), .i_borrow_in(w_b_cs_dez), .o_digit(w_s_uni), .o_borrow_out(w_b_s_uni)
    );

    bcd_digit_down #(.WRAP(SEG_DEZ_MAX)) u_s_dez (
        .i_clk(i_clk_100hz), .i_rst_n(i_reset), .i_clr(w_clr), .i_ld(w_ld),
        .i_ld_val(clamp_bcd(i_preset_s_dez, SEG_DEZ_MAX)),
        .i_en(w_dec_en), .i_borrow_in(w_b_s_uni), .o_digit(w_s_dez), .o_borrow_out(w_b_s_dez)
    );

    assign o_cs_unidade = w_cs_uni;
    assign o_cs_dezena  = w_cs_dez;
    assign o_s_unidade  = w_s_uni;
    assign o_s_dezena   = w_s_dez;
    assign o_running    = r_running;
    assign o_done       = r_done;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Bench for the count-down timer: directed scenarios plus random stimulus against a
// reference that tracks the remaining time as an integer count of hundredths.
module tb_temporizador_regressivo;

    localparam int ALARM = 200;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic       clk = 1'b0;
    logic       rst_n, clr, ld, ss;
    logic [3:0] pd, pu;
    logic [3:0] cs_uni, cs_dez, s_uni, s_dez;
    logic       running, done;

    int vectors     = 0;
    int miscompares = 0;

    int m_val, m_state, m_alarm;
    bit m_prev;

    always #5 clk = ~clk;

    temporizador_regressivo dut (
        .i_clk_100hz   (clk),
        .i_reset       (rst_n),
        .i_clear       (clr),
        .i_load        (ld),
        .i_preset_s_dez(pd),
        .i_preset_s_uni(pu),
        .i_start_stop  (ss),
        .o_cs_unidade  (cs_uni),
        .o_cs_dezena   (cs_dez),
        .o_s_unidade   (s_uni),
        .o_s_dezena    (s_dez),
        .o_running     (running),
        .o_done        (done)
    );

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int clampi(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    task automatic model_step();
        bit e;
        e = ss && !m_prev;
        if (!rst_n) begin
            m_val = 0; m_state = M_IDLE; m_alarm = 0; m_prev = 0;
        end else begin
            m_prev = ss;
            if (clr) begin
                m_val = 0; m_state = M_IDLE; m_alarm = 0;
            end else if (ld && m_state != M_RUN) begin
                m_val   = clampi(int'(pd), 5) * 1000 + clampi(int'(pu), 9) * 100;
                m_state = M_IDLE; m_alarm = 0;
            end else if (m_state == M_IDLE) begin
                if (e && m_val != 0) m_state = M_RUN;
            end else if (m_state == M_RUN) begin
                if (e) m_state = M_PAUSE;
                else begin
                    m_val = m_val - 1;
                    if (m_val == 0) begin m_state = M_DONE; m_alarm = 0; end
                end
            end else if (m_state == M_PAUSE) begin
                if (e) m_state = M_RUN;
            end else begin
                m_alarm = m_alarm + 1;
                if (e || m_alarm >= ALARM) begin m_state = M_IDLE; m_alarm = 0; end
            end
        end
    endtask

    function automatic logic [17:0] observed();
        return {s_dez, s_uni, cs_dez, cs_uni, running, done};
    endfunction

    task automatic cycle();
        logic [17:0] exp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        exp = {to_bcd(m_val), m_state == M_RUN, m_state == M_DONE};
        vectors++;
        assert (observed() === exp) else begin
            miscompares++;
            $error("FAIL model: got %h want %h (t=%0t)", observed(), exp, $time);
        end
    endtask

    task automatic check_const(input string tag, input logic [17:0] exp);
        vectors++;
        assert (observed() === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h want %h", tag, observed(), exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ld = 1'b0; ss = 1'b0; pd = 4'd0; pu = 4'd0;
        m_val = 0; m_state = M_IDLE; m_alarm = 0; m_prev = 0;
        @(negedge clk);
        cycle();
        check_const("reset", {16'h0000, 2'b00});
        rst_n = 1'b1;

        // preset 02.00, run to expiry and through the full alarm
        ld = 1'b1; pd = 4'd0; pu = 4'd2; cycle(); ld = 1'b0;
        check_const("load_02", {16'h0200, 2'b00});
        ss = 1'b1; cycle(); ss = 1'b0;
        check_const("start", {16'h0200, 2'b10});
        repeat (3) cycle();
        check_const("dec3", {16'h0197, 2'b10});
        repeat (197) cycle();
        check_const("expire", {16'h0000, 2'b01});
        repeat (ALARM - 1) cycle();
        check_const("alarm_last", {16'h0000, 2'b01});
        cycle();
        check_const("alarm_end", {16'h0000, 2'b00});

        // reset in the middle of a run at 12.34
        ld = 1'b1; pd = 4'd1; pu = 4'd3; cycle(); ld = 1'b0;
        ss = 1'b1; cycle(); ss = 1'b0;
        repeat (66) cycle();
        check_const("run_1234", {16'h1234, 2'b10});
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        check_const("reset_run", {16'h0000, 2'b00});

        // triple borrow, pause and hold
        ld = 1'b1; pd = 4'd1; pu = 4'd0; cycle(); ld = 1'b0;
        ss = 1'b1; cycle(); ss = 1'b0;
        cycle();
        check_const("borrow3", {16'h0999, 2'b10});
        ss = 1'b1; cycle(); ss = 1'b0;
        check_const("pause", {16'h0999, 2'b00});
        repeat (50) cycle();
        check_const("hold50", {16'h0999, 2'b00});

        // load ignored in RUN; load beats edge in PAUSE
        ss = 1'b1; cycle(); ss = 1'b0;
        cycle();
        ld = 1'b1; pd = 4'd3; pu = 4'd3; cycle(); ld = 1'b0;
        check_const("load_in_run", {16'h0997, 2'b10});
        ss = 1'b1; cycle(); ss = 1'b0;
        cycle();
        ld = 1'b1; pd = 4'd4; pu = 4'd5; ss = 1'b1; cycle(); ld = 1'b0; ss = 1'b0;
        check_const("load_wins", {16'h4500, 2'b00});
        cycle();
        check_const("load_idle", {16'h4500, 2'b00});

        // clamped preset, clear, start at 00.00 ignored
        ld = 1'b1; pd = 4'd7; pu = 4'd12; cycle(); ld = 1'b0;
        check_const("clamp", {16'h5900, 2'b00});
        clr = 1'b1; cycle(); clr = 1'b0;
        check_const("clear", {16'h0000, 2'b00});
        ss = 1'b1; cycle(); ss = 1'b0;
        check_const("start_zero", {16'h0000, 2'b00});

        // early acknowledge of the alarm
        ld = 1'b1; pd = 4'd0; pu = 4'd1; cycle(); ld = 1'b0;
        ss = 1'b1; cycle(); ss = 1'b0;
        repeat (100) cycle();
        check_const("expire2", {16'h0000, 2'b01});
        repeat (10) cycle();
        check_const("alarm10", {16'h0000, 2'b01});
        ss = 1'b1; cycle(); ss = 1'b0;
        check_const("ack", {16'h0000, 2'b00});

        // random stimulus
        repeat (4000) begin
            rst_n = ($urandom_range(0, 299) != 0);
            clr   = ($urandom_range(0, 149) == 0);
            ld    = ($urandom_range(0, 59) == 0);
            pd    = 4'($urandom_range(0, 15));
            pu    = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) ss = ~ss;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
